freq_meter: RTL and testbench
=============================

Name: freq_meter

Overview:
- Gated-window frequency counter; the inverse of the clock divider: it measures an incoming slow signal instead of generating one.
- Counts rising edges of an asynchronous input (pulse sensor, tone feedback, divided-clock self-check) over a fixed window of Clk cycles.
- Reports the count once per window with a one-cycle Valid strobe.
- Sits beside the divider and feeds the FSM, 7-seg and LCD display paths.

Parameters:
- GATE_CYCLES, 40_000_000, window length in Clk cycles (1 s at 40 MHz); must be >= 2.
- CNT_W, 16, width of edge counter and Freq output.

Ports:
- Clk    input   1      system clock; all logic on posedge.
- Rst_n  input   1      synchronous reset, active low.
- En     input   1      1 = measure continuously; 0 = stop/abort.
- SigIn  input   1      asynchronous signal under measurement.
- Freq   output  CNT_W  rising edges counted in last completed window.
- Valid  output  1      one-cycle strobe when Freq/Ovf update.
- Ovf    output  1      last completed window saturated the counter.
- Busy   output  1      high while in GATE or REPORT.

Behaviour:
- Reset:
  - Rst_n=0 sampled at posedge: state IDLE; Freq=0, Valid=0, Ovf=0, Busy=0.
  - Sync flops, edge-detect flop, gate counter, edge counter and overflow-pending flag all cleared.
  - Reset mid-window discards the partial window; no Valid is produced.
- Input path:
  - SigIn passes through a 2-flop synchronizer, then an edge-detect flop.
  - Edge event = sync2 & ~prev.
  - Latency: SigIn rise to edge event = 3 Clk edges.
  - Max countable rate: one edge per 2 Clk cycles; faster input aliases and is not guaranteed.
- State machine: IDLE, GATE, REPORT.
- IDLE:
  - Busy=0; counters held at 0.
  - En=1 -> GATE on the next cycle with gate counter=0 and edge counter=0. Edges seen in the IDLE cycle are ignored.
- GATE:
  - Busy=1; gate counter increments every cycle.
  - Each edge event increments the edge counter.
  - At 2^CNT_W-1 the edge counter holds its value and sets the overflow-pending flag.
  - When gate counter == GATE_CYCLES-1: an edge in that cycle is still counted; next state REPORT.
  - En=0 in any GATE cycle -> IDLE next cycle (abort); Freq/Ovf unchanged; no Valid.
- REPORT:
  - Lasts exactly one cycle: Freq <= final count (including any last-cycle edge); Ovf <= overflow-pending.
  - Valid is high for exactly that cycle.
  - En=1 -> GATE. Gate counter=0; edge counter = 1 if an edge occurs in the REPORT cycle, else 0; pending cleared. No edge is lost between windows.
  - En=0 -> IDLE.
- Continuous-mode timing: Valid period = GATE_CYCLES+1 Clk cycles.
- Freq and Ovf hold between Valid strobes.
- Valid is never high for two consecutive cycles.
- Gate counter width = clog2(GATE_CYCLES); it never wraps.

Optional Feature:
- Macro: FREQ_AVG_EN.
- Defined:
  - A 4-entry history of completed window counts, each with its overflow flag.
  - History is cleared to 0 on reset and on each IDLE->GATE transition; it shifts at REPORT.
  - Freq = (sum of the 4 entries) >> 2, truncated. The sum is computed at CNT_W+2 bits.
  - Ovf = OR of the 4 stored overflow flags.
  - The first three reports after start average in zeros.
- Not defined: Freq is the raw count of the last window; no history logic is synthesized.

Test Plan:
- Sim parameters: GATE_CYCLES=100, CNT_W=16 unless noted.
- Reset: Rst_n=0 for 3 cycles with SigIn toggling -> Freq=0, Valid=0, Ovf=0, Busy=0; Rst_n=1 with En=0 keeps all outputs 0 for 200 cycles.
- Basic count: En=1; SigIn period 10 cycles, phase-aligned so the 3-flop input path delivers exactly 10 edge events per window -> first Valid 101 cycles after GATE entry; Freq=10, Ovf=0; subsequent Valid strobes exactly 101 cycles apart.
- Boundary edges: edge events forced on the final GATE cycle and on the REPORT cycle -> final-cycle edge counted in the current report; REPORT-cycle edge appears in the next report; totals across windows match edges applied.
- Overflow (CNT_W=4): SigIn period 2 cycles (about 50 edges) -> Freq=15, Ovf=1; next window with 5 edges -> Freq=5, Ovf=0.
- Abort and reset mid-window: En=0 at gate count 50 -> no Valid, Freq keeps the prior value, Busy=0 next cycle; Rst_n=0 at gate count 50 -> all outputs 0, no Valid.
- FREQ_AVG_EN: windows of 8, 8, 8, 8, 0 edges -> Freq reports 2, 4, 6, 8, 6.

Source files
------------

// File: rtl/freq_meter.sv
// Gated-window frequency counter: counts synchronized rising edges of SigIn over
// GATE_CYCLES clocks and reports once per window. Define FREQ_AVG_EN for a 4-window average.
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 40_000_000,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             En,
  input  logic             SigIn,
  output logic [CNT_W-1:0] Freq,
  output logic             Valid,
  output logic             Ovf,
  output logic             Busy
);

  localparam int unsigned GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_GATE   = 2'd1;
  localparam logic [1:0] S_REPORT = 2'd2;

  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic             sync1_q, sync2_q, prev_q;
  logic             edge_ev;
  logic [1:0]       state_q, state_d;
  logic [GW-1:0]    gate_q, gate_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_next;
  logic             pend_q, pend_d, pend_next;
  logic [CNT_W-1:0] freq_q, freq_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;

`ifdef FREQ_AVG_EN
  logic [CNT_W-1:0] hist_q [4];
  logic [CNT_W-1:0] hist_d [4];
  logic [3:0]       hovf_q, hovf_d;
  logic [CNT_W+1:0] hsum;
`endif

  always_comb begin
    edge_ev   = sync2_q & ~prev_q;
    cnt_next  = cnt_q;
    pend_next = pend_q;
    if (edge_ev) begin
      if (cnt_q == CNT_MAX) pend_next = 1'b1;
      else                  cnt_next  = cnt_q + 1'b1;
    end

    state_d = state_q;
    gate_d  = gate_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    freq_d  = freq_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
`ifdef FREQ_AVG_EN
    for (int unsigned i = 0; i < 4; i++) hist_d[i] = hist_q[i];
    hovf_d = hovf_q;
    hsum   = '0;
`endif

    case (state_q)
      S_IDLE: begin
        gate_d = '0;
        cnt_d  = '0;
        pend_d = 1'b0;
        if (En) begin
          state_d = S_GATE;
`ifdef FREQ_AVG_EN
          for (int unsigned i = 0; i < 4; i++) hist_d[i] = '0;
          hovf_d = '0;
`endif
        end
      end
      S_GATE: begin
        if (!En) begin
          state_d = S_IDLE;
          gate_d  = '0;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end else begin
          cnt_d  = cnt_next;
          pend_d = pend_next;
          // Result is registered on the way into REPORT so Freq is already
          // current while Valid is high, including a final-cycle edge.
          if (gate_q == GATE_LAST) begin
            state_d = S_REPORT;
            gate_d  = '0;
            valid_d = 1'b1;
`ifdef FREQ_AVG_EN
            hist_d[0] = cnt_next;
            hist_d[1] = hist_q[0];
            hist_d[2] = hist_q[1];
            hist_d[3] = hist_q[2];
            hovf_d    = {hovf_q[2:0], pend_next};
            hsum      = (CNT_W+2)'(cnt_next) + (CNT_W+2)'(hist_q[0])
                      + (CNT_W+2)'(hist_q[1]) + (CNT_W+2)'(hist_q[2]);
            freq_d    = hsum[CNT_W+1:2];
            ovf_d     = |hovf_d;
`else
            freq_d    = cnt_next;
            ovf_d     = pend_next;
`endif
          end else begin
            gate_d = gate_q + 1'b1;
          end
        end
      end
      S_REPORT: begin
        gate_d = '0;
        pend_d = 1'b0;
        if (En) begin
          state_d = S_GATE;
          cnt_d   = CNT_W'(edge_ev);
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        gate_d  = '0;
        cnt_d   = '0;
        pend_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      state_q <= S_IDLE;
      gate_q  <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      freq_q  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
`ifdef FREQ_AVG_EN
      for (int unsigned i = 0; i < 4; i++) hist_q[i] <= '0;
      hovf_q <= '0;
`endif
    end else begin
      sync1_q <= SigIn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      gate_q  <= gate_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      freq_q  <= freq_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
`ifdef FREQ_AVG_EN
      for (int unsigned i = 0; i < 4; i++) hist_q[i] <= hist_d[i];
      hovf_q <= hovf_d;
`endif
    end
  end

  assign Freq  = freq_q;
  assign Valid = valid_q;
  assign Ovf   = ovf_q;
  assign Busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter: a 16-bit and a 4-bit instance share one stimulus;
// expected reports are queued per window and popped on each Valid strobe.
module tb_freq_meter;

  localparam int GC    = 100;
  localparam int WP    = GC + 1;
  localparam int NWMAX = 6;
  localparam int EVN   = NWMAX * WP + 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, sig;
  logic [15:0] freq16;
  logic        valid16, ovf16, busy16;
  logic [3:0]  freq4;
  logic        valid4, ovf4, busy4;

  freq_meter #(.GATE_CYCLES(GC), .CNT_W(16)) u_dut16 (
    .Clk(clk), .Rst_n(rst_n), .En(en), .SigIn(sig),
    .Freq(freq16), .Valid(valid16), .Ovf(ovf16), .Busy(busy16)
  );

  freq_meter #(.GATE_CYCLES(GC), .CNT_W(4)) u_dut4 (
    .Clk(clk), .Rst_n(rst_n), .En(en), .SigIn(sig),
    .Freq(freq4), .Valid(valid4), .Ovf(ovf4), .Busy(busy4)
  );

  typedef struct {
    logic [15:0] f;
    logic        o;
  } exp_t;

  exp_t        q16[$];
  exp_t        q4[$];
  int unsigned h16[4];
  int unsigned h4[4];
  bit          ho16[4];
  bit          ho4[4];
  logic [15:0] last_f16, last_f4;
  logic        last_o16, last_o4;
  bit          ev[EVN];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit ev_at(input int x);
    if (x < 0 || x >= EVN) return 1'b0;
    return ev[x];
  endfunction

  task automatic ev_clear();
    for (int i = 0; i < EVN; i++) ev[i] = 1'b0;
  endtask

  // pos 0..GC-1 are GATE cycles of window w, pos GC is its REPORT cycle
  task automatic add_ev(input int w, input int pos);
    ev[w*WP + pos] = 1'b1;
  endtask

  task automatic hist_clear();
    for (int i = 0; i < 4; i++) begin
      h16[i] = 0; h4[i] = 0; ho16[i] = 1'b0; ho4[i] = 1'b0;
    end
  endtask

  task automatic push_window(input int unsigned raw);
    exp_t        e16, e4;
    int unsigned c16, c4;
    bit          o16, o4;
    c16 = (raw > 65535) ? 65535 : raw;
    o16 = (raw > 65535);
    c4  = (raw > 15) ? 15 : raw;
    o4  = (raw > 15);
`ifdef FREQ_AVG_EN
    for (int i = 3; i > 0; i--) begin
      h16[i] = h16[i-1]; ho16[i] = ho16[i-1];
      h4[i]  = h4[i-1];  ho4[i]  = ho4[i-1];
    end
    h16[0] = c16; ho16[0] = o16;
    h4[0]  = c4;  ho4[0]  = o4;
    e16.f = 16'((h16[0] + h16[1] + h16[2] + h16[3]) >> 2);
    e16.o = ho16[0] | ho16[1] | ho16[2] | ho16[3];
    e4.f  = 16'((h4[0] + h4[1] + h4[2] + h4[3]) >> 2);
    e4.o  = ho4[0] | ho4[1] | ho4[2] | ho4[3];
`else
    e16.f = 16'(c16); e16.o = o16;
    e4.f  = 16'(c4);  e4.o  = o4;
`endif
    q16.push_back(e16);
    q4.push_back(e4);
    last_f16 = e16.f; last_o16 = e16.o;
    last_f4  = e4.f;  last_o4  = e4.o;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic sample_valid(input int t, input int nwin);
    exp_t e;
    bit   slot;
    slot = (t >= 0) && (t < nwin*WP) && ((t % WP) == GC);
    if (slot) begin
      check("valid16_slot", 32'(valid16), 32'd1);
      check("valid4_slot", 32'(valid4), 32'd1);
    end else begin
      if (valid16) check("valid16_extra", 32'(valid16), 32'd0);
      if (valid4)  check("valid4_extra", 32'(valid4), 32'd0);
    end
    if (valid16) begin
      if (q16.size() == 0) check("sb16_empty", 32'(q16.size()), 32'd1);
      else begin
        e = q16.pop_front();
        check("freq16", 32'(freq16), 32'(e.f));
        check("ovf16", 32'(ovf16), 32'(e.o));
      end
    end
    if (valid4) begin
      if (q4.size() == 0) check("sb4_empty", 32'(q4.size()), 32'd1);
      else begin
        e = q4.pop_front();
        check("freq4", 32'(freq4), 32'(e.f));
        check("ovf4", 32'(ovf4), 32'(e.o));
      end
    end
  endtask

  // Continuous run of nwin windows; t=0 is the first GATE cycle.
  // An event planned for cycle c needs SigIn high in cycle c-2.
  task automatic run_cont(input int nwin);
    int unsigned raw;
    hist_clear();
    for (int w = 0; w < nwin; w++) begin
      raw = 0;
      for (int c = 0; c < GC; c++) raw += ev[w*WP + c];
      if (w > 0) raw += ev[w*WP - 1];
      push_window(raw);
    end
    for (int t = -2; t <= nwin*WP; t++) begin
      @(posedge clk); #1;
      en  = (t >= -1) && (t < nwin*WP - 1);
      sig = ev_at(t + 2);
      sample_valid(t, nwin);
      if (t == 0) check("busy_gate", 32'(busy16), 32'd1);
      if (t == nwin*WP) check("busy_idle", 32'(busy16), 32'd0);
    end
    check("sb16_drain", 32'(q16.size()), 32'd0);
    check("sb4_drain", 32'(q4.size()), 32'd0);
  endtask

  // Window cut short at gate count 50 by En=0 or by Rst_n=0.
  task automatic run_abort(input bit use_reset);
    ev_clear();
    add_ev(0, 10); add_ev(0, 20); add_ev(0, 30);
    for (int t = -2; t <= 55; t++) begin
      @(posedge clk); #1;
      en = (t >= -1) && (t < 50);
      if (use_reset) rst_n = (t != 50);
      sig = ev_at(t + 2);
      if (valid16) check("abort_valid16", 32'(valid16), 32'd0);
      if (valid4)  check("abort_valid4", 32'(valid4), 32'd0);
      if (t == 50) check("abort_busy_pre", 32'(busy16), 32'd1);
      if (t == 51) begin
        if (use_reset) begin
          last_f16 = '0; last_o16 = 1'b0; last_f4 = '0; last_o4 = 1'b0;
        end
        check("abort_busy", 32'(busy16), 32'd0);
        check("abort_freq16", 32'(freq16), 32'(last_f16));
        check("abort_ovf16", 32'(ovf16), 32'(last_o16));
        check("abort_freq4", 32'(freq4), 32'(last_f4));
        check("abort_ovf4", 32'(ovf4), 32'(last_o4));
      end
    end
  endtask

  int nz;

  initial begin
    rst_n = 1'b0; en = 1'b0; sig = 1'b0;
    hist_clear();
    last_f16 = '0; last_o16 = 1'b0; last_f4 = '0; last_o4 = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      sig = ~sig;
    end
    check("rst_freq16", 32'(freq16), 32'd0);
    check("rst_valid16", 32'(valid16), 32'd0);
    check("rst_ovf16", 32'(ovf16), 32'd0);
    check("rst_busy16", 32'(busy16), 32'd0);
    check("rst_freq4", 32'(freq4), 32'd0);
    check("rst_busy4", 32'(busy4), 32'd0);

    rst_n = 1'b1;
    nz = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      sig = (i % 3 == 0);
      if (freq16 != 0 || valid16 || ovf16 || busy16 || freq4 != 0 || valid4 || ovf4 || busy4) nz++;
    end
    check("idle_hold", 32'(nz), 32'd0);
    sig = 1'b0;
    idle(4);

    // basic: period-10 pulses, 10 per window
    ev_clear();
    for (int w = 0; w < 3; w++)
      for (int k = 0; k < 10; k++) add_ev(w, 5 + 10*k);
    run_cont(3);

    // boundary: last GATE cycle of w0, REPORT cycle of w1 (counts in w2)
    ev_clear();
    add_ev(0, 10); add_ev(0, 20); add_ev(0, 99);
    add_ev(1, 50); add_ev(1, 98); add_ev(1, GC);
    add_ev(2, 30);
    run_cont(3);

    // overflow on the 4-bit instance: 50 edges then 5 edges
    ev_clear();
    for (int k = 0; k < 50; k++) add_ev(0, 2*k);
    for (int k = 1; k <= 5; k++) add_ev(1, 10*k);
    run_cont(2);

    run_abort(1'b0);
    ev_clear();
    for (int k = 1; k <= 7; k++) add_ev(0, 12*k);
    run_cont(1);

    run_abort(1'b1);
    ev_clear();
    for (int k = 1; k <= 4; k++) add_ev(0, 20*k);
    run_cont(1);

    // 8,8,8,8,0 edges (averaged build reports 2,4,6,8,6)
    ev_clear();
    for (int w = 0; w < 4; w++)
      for (int k = 1; k <= 8; k++) add_ev(w, 10*k);
    run_cont(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
